if_fetch_queue: RTL and testbench

Instruction-fetch stage between the PC register and the IF/ID pipeline register. It takes the current PC, issues one instruction-memory request at a time over a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO. It tells the PC register when to advance. It absorbs ID-stage stalls, and discards everything, including any in-flight response, on a branch flush.

---
 rtl/if_fetch_queue_if.sv | 24 ++
 rtl/if_fetch_queue.sv | 142 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory request bus between the fetch queue (master) and instruction memory (slave).
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [DATA_W-1:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Fetch stage: one outstanding imem request, results queued with their PCs in a DEPTH-entry FIFO.
// Define FETCH_BYPASS_EN to present an ack'd instruction on the outputs in the same cycle when empty.
module if_fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       pc_i,
  output logic                    pc_advance_o,
  input  logic                    flush_i,
  input  logic                    stall_i,
  if_fetch_queue_if.master        imem,
  output logic                    inst_valid_o,
  output logic [DATA_W-1:0]       inst_o,
  output logic [ADDR_W-1:0]       inst_pc_o,
  output logic [1:0]              state_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  // Handshakes: imem_req_o rises with a stable imem_addr_o and holds until the single-cycle
  // imem_ack_i; the head entry transfers to ID on any cycle with inst_valid_o & ~stall_i & ~flush_i.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_inst_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic w_issue;
  logic w_ack_ok;
  logic w_empty;
  logic w_bypass;
  logic w_valid;
  logic w_pop;
  logic w_fifo_pop;
  logic w_push;

  // Reset gates issue so the PC register cannot advance while the stage is being cleared.
  assign w_issue  = (r_state == IDLE) & start_i & ~flush_i & (r_count < CW'(DEPTH)) & ~rst_i;
  assign w_ack_ok = (r_state == REQ) & imem.imem_ack_i & ~flush_i;
  assign w_empty  = (r_count == '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_ack_ok & w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_valid    = ~w_empty | w_bypass;
  assign w_pop      = w_valid & ~stall_i & ~flush_i;
  // A bypassed instruction consumed this cycle never touches the storage.
  assign w_fifo_pop = w_pop & ~w_empty;
  assign w_push     = w_ack_ok & ~(w_bypass & ~stall_i);

  assign pc_advance_o     = w_issue;
  assign imem.imem_req_o  = r_req;
  assign imem.imem_addr_o = r_addr;
  assign inst_valid_o     = w_valid;
  assign inst_o           = w_bypass ? imem.imem_data_i : r_inst_mem[r_rptr];
  assign inst_pc_o        = w_bypass ? r_addr : r_pc_mem[r_rptr];
  assign state_o          = r_state;
  assign count_o          = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_addr  <= pc_i;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (imem.imem_ack_i) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end else if (flush_i) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (imem.imem_ack_i) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_inst_mem[i] <= '0;
        r_pc_mem[i]   <= '0;
      end
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_inst_mem[r_wptr] <= imem.imem_data_i;
        r_pc_mem[r_wptr]   <= r_addr;
        r_wptr             <= r_wptr + PW'(1);
      end
      if (w_fifo_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_fifo_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed table-driven bench for if_fetch_queue plus hand-written reset and idle sequences.
module tb_if_fetch_queue;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_advance_o;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [1:0]  state_o;
  logic [1:0]  count_o;

  if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) imem ();

  if_fetch_queue #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .pc_advance_o (pc_advance_o),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .imem         (imem.master),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .state_o      (state_o),
    .count_o      (count_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start, flush, stall, ack;
    logic [31:0] pc, data;
    logic        adv, req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] inst, ipc;
    logic [1:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(logic st, logic fl, logic sl, logic ak, logic [31:0] pc,
                              logic [31:0] data, logic adv, logic req, logic [31:0] addr,
                              logic valid, logic [31:0] inst, logic [31:0] ipc, logic [1:0] cnt);
    vec_t v;
    v.start = st; v.flush = fl; v.stall = sl; v.ack = ak; v.pc = pc; v.data = data;
    v.adv = adv; v.req = req; v.addr = addr; v.valid = valid; v.inst = inst; v.ipc = ipc;
    v.cnt = cnt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(logic st, logic fl, logic sl, logic ak, logic [31:0] pc, logic [31:0] d);
    start_i = st; flush_i = fl; stall_i = sl; imem.imem_ack_i = ak; pc_i = pc; imem.imem_data_i = d;
  endtask

  initial begin
    imem.imem_ack_i  = 1'b0;
    imem.imem_data_i = '0;

    //            st fl sl ak pc         data          adv req addr      vld  inst                    ipc                 cnt
    vecs.push_back(mk(0,0,0,0, 32'h100, 32'h0,        0,0, 32'h0,   0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,0,1,0, 32'h100, 32'h0,        1,0, 32'h0,   0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,0,1,1, 32'h104, 32'h00500093, 0,1, 32'h100, BYP, 32'h00500093,           32'h100,            2'd0));
    vecs.push_back(mk(0,0,1,0, 32'h104, 32'h0,        0,0, 32'h100, 1,   32'h00500093,           32'h100,            2'd1));
    vecs.push_back(mk(0,0,0,0, 32'h104, 32'h0,        0,0, 32'h100, 1,   32'h00500093,           32'h100,            2'd1));
    vecs.push_back(mk(0,0,0,0, 32'h104, 32'h0,        0,0, 32'h100, 0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,0,1,0, 32'h0,   32'h0,        1,0, 32'h100, 0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,0,1,1, 32'h4,   32'hAAAA0001, 0,1, 32'h0,   BYP, 32'hAAAA0001,           32'h0,              2'd0));
    vecs.push_back(mk(1,0,1,0, 32'h4,   32'h0,        1,0, 32'h0,   1,   32'hAAAA0001,           32'h0,              2'd1));
    vecs.push_back(mk(1,0,1,1, 32'h8,   32'hBBBB0002, 0,1, 32'h4,   1,   32'hAAAA0001,           32'h0,              2'd1));
    vecs.push_back(mk(1,0,1,0, 32'h8,   32'h0,        0,0, 32'h4,   1,   32'hAAAA0001,           32'h0,              2'd2));
    vecs.push_back(mk(1,0,1,0, 32'h8,   32'h0,        0,0, 32'h4,   1,   32'hAAAA0001,           32'h0,              2'd2));
    vecs.push_back(mk(0,0,0,0, 32'h8,   32'h0,        0,0, 32'h4,   1,   32'hAAAA0001,           32'h0,              2'd2));
    vecs.push_back(mk(0,0,0,0, 32'h8,   32'h0,        0,0, 32'h4,   1,   32'hBBBB0002,           32'h4,              2'd1));
    vecs.push_back(mk(0,0,0,0, 32'h8,   32'h0,        0,0, 32'h4,   0,   32'h0,                  32'h0,              2'd0));
    // flush while the request for 0x8 is outstanding, redirect to 0x200
    vecs.push_back(mk(1,0,0,0, 32'h8,   32'h0,        1,0, 32'h4,   0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,1,0,0, 32'h200, 32'h0,        0,1, 32'h8,   0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,0,0,0, 32'h200, 32'h0,        0,1, 32'h8,   0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,0,0,1, 32'h200, 32'hDEAD0000, 0,1, 32'h8,   0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,0,0,0, 32'h200, 32'h0,        1,0, 32'h8,   0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,0,0,0, 32'h204, 32'h0,        0,1, 32'h200, 0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(1,0,1,1, 32'h204, 32'h11111111, 0,1, 32'h200, BYP, 32'h11111111,           32'h200,            2'd0));
    // count==1 with ack and pop together
    vecs.push_back(mk(1,0,1,0, 32'h204, 32'h0,        1,0, 32'h200, 1,   32'h11111111,           32'h200,            2'd1));
    vecs.push_back(mk(0,0,0,1, 32'h208, 32'h22222222, 0,1, 32'h204, 1,   32'h11111111,           32'h200,            2'd1));
    vecs.push_back(mk(0,0,1,0, 32'h208, 32'h0,        0,0, 32'h204, 1,   32'h22222222,           32'h204,            2'd1));
    vecs.push_back(mk(1,1,0,0, 32'h208, 32'h0,        0,0, 32'h204, 1,   32'h22222222,           32'h204,            2'd1));
    vecs.push_back(mk(0,0,0,0, 32'h300, 32'h0,        0,0, 32'h204, 0,   32'h0,                  32'h0,              2'd0));
    // flush and ack in the same cycle
    vecs.push_back(mk(1,0,0,0, 32'h300, 32'h0,        1,0, 32'h204, 0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(0,1,0,1, 32'h300, 32'h33333333, 0,1, 32'h300, 0,   32'h0,                  32'h0,              2'd0));
    vecs.push_back(mk(0,0,0,0, 32'h300, 32'h0,        0,0, 32'h300, 0,   32'h0,                  32'h0,              2'd0));

    // reset state
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_req",   {31'h0, imem.imem_req_o}, 32'h0);
    check("rst_addr",  imem.imem_addr_o, 32'h0);
    check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    check("rst_inst",  inst_o, 32'h0);
    check("rst_pc",    inst_pc_o, 32'h0);
    check("rst_adv",   {31'h0, pc_advance_o}, 32'h0);
    check("rst_state", {30'h0, state_o}, 32'h0);
    tick();

    // table vectors: one row per cycle, outputs sampled on the falling edge
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].flush, vecs[i].stall, vecs[i].ack, vecs[i].pc, vecs[i].data);
      @(negedge clk_i);
      check($sformatf("v%0d_adv", i),   {31'h0, pc_advance_o}, {31'h0, vecs[i].adv});
      check($sformatf("v%0d_req", i),   {31'h0, imem.imem_req_o}, {31'h0, vecs[i].req});
      check($sformatf("v%0d_addr", i),  imem.imem_addr_o, vecs[i].addr);
      check($sformatf("v%0d_valid", i), {31'h0, inst_valid_o}, {31'h0, vecs[i].valid});
      check($sformatf("v%0d_cnt", i),   {30'h0, count_o}, {30'h0, vecs[i].cnt});
      if (vecs[i].valid) begin
        check($sformatf("v%0d_inst", i), inst_o, vecs[i].inst);
        check($sformatf("v%0d_ipc", i),  inst_pc_o, vecs[i].ipc);
      end
      tick();
    end

    // reset asserted mid-request with one entry queued
    drive(1, 0, 1, 0, 32'h400, 32'h0);
    tick();
    drive(0, 0, 1, 1, 32'h404, 32'h44444444);
    tick();
    drive(1, 0, 1, 0, 32'h404, 32'h0);
    tick();
    check("mid_pre_req",   {31'h0, imem.imem_req_o}, 32'h1);
    check("mid_pre_valid", {31'h0, inst_valid_o}, 32'h1);
    rst_i = 1'b1;
    #1;
    check("mid_req",   {31'h0, imem.imem_req_o}, 32'h0);
    check("mid_valid", {31'h0, inst_valid_o}, 32'h0);
    check("mid_adv",   {31'h0, pc_advance_o}, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    drive(1, 0, 0, 0, 32'h500, 32'h0);
    @(negedge clk_i);
    check("post_rst_adv", {31'h0, pc_advance_o}, 32'h1);
    tick();
    check("post_rst_req",  {31'h0, imem.imem_req_o}, 32'h1);
    check("post_rst_addr", imem.imem_addr_o, 32'h500);
    drive(0, 0, 0, 1, 32'h504, 32'h55555555);
    tick();
    drive(0, 0, 0, 0, 32'h504, 32'h0);

    // start_i low for 10 cycles: nothing issued
    for (int i = 0; i < 10; i++) begin
      pc_i = 32'($urandom_range(0, 255)) << 2;
      @(negedge clk_i);
      check($sformatf("idle%0d_req", i), {31'h0, imem.imem_req_o}, 32'h0);
      check($sformatf("idle%0d_adv", i), {31'h0, pc_advance_o}, 32'h0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, tests run %0d", n_tests);
    $fatal(1);
  end
endmodule
